// File: rtl/pat_pkg.sv
// Shared definitions for the pat_ser serializer.
//   state_t       : serializer FSM state (IDLE = shifter empty, SHIFT = emitting bits)
//   IDLE_LEVEL    : line level driven on data whenever no payload bit is present
//   DEFAULT_WIDTH : default word width used by the serializer and its interface
package pat_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_LEVEL    = 1'b1;
    localparam int   DEFAULT_WIDTH = 8;

endpackage

// File: rtl/pat_ser_if.sv
// Handshake and serial-output bundle for pat_ser.
//   in_valid, in_data : upstream parallel word offer
//   in_ready          : serializer can take a word this cycle
//   data, data_valid  : serial bit stream and its qualifier
//   busy              : serializer holds or emits a word
// Modports: master = upstream word source / stream observer, slave = serializer.
interface pat_ser_if
    import pat_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             data;
    logic             data_valid;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data,
        input  data_valid,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data,
        output data_valid,
        output busy
    );

endinterface

// File: rtl/pat_ser.sv
// pat_ser: parallel-to-serial converter feeding a downstream pattern detector.
// A one-word hold register sits in front of a shift register, so a word can
// be accepted while the previous one is still being emitted and consecutive
// words come out back to back with no gap bit.
// Ports:
//   clk      : single clock, rising edge
//   reset    : synchronous, active-low
//   bus      : pat_ser_if.slave (in_valid/in_data/in_ready, data/data_valid, busy)
//   byte_cnt : 16-bit count of fully emitted words (only with PAT_SER_BYTE_CNT_EN)
// Parameters: WIDTH (2..16 bits per word), MSB_FIRST (1 = MSB first, 0 = LSB first).
// Optional feature macro: PAT_SER_BYTE_CNT_EN adds the byte_cnt output.
module pat_ser
    import pat_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
`ifdef PAT_SER_BYTE_CNT_EN
    output logic [15:0] byte_cnt,
`endif
    pat_ser_if.slave    bus
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic             hold_full;
    logic [WIDTH-1:0] hold_word;
    logic [WIDTH-1:0] shift_word;
    logic [CNT_W-1:0] bit_cnt;
    logic             data_q;
    logic             data_valid_q;

    logic             last_bit;
    logic             shifter_free;
    logic             move;
    logic             take;
    logic [WIDTH-1:0] load_word;

    // Bit that goes on the line next, taken from the leading end of the word.
    function automatic logic lead_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Drop the bit just emitted so the next one sits at the leading end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    // The shifter can take a new word when empty or while its last bit is on
    // the line; the held word has priority over a fresh upstream word.
    assign last_bit     = (state == SHIFT) && (bit_cnt == LAST_IDX);
    assign shifter_free = (state == IDLE) || last_bit;
    assign move         = shifter_free && (hold_full || bus.in_valid);
    assign load_word    = hold_full ? hold_word : bus.in_data;

    assign bus.in_ready = reset && (!hold_full || move);
    assign take         = bus.in_valid && bus.in_ready;

    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = (state == SHIFT) || hold_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            hold_full    <= 1'b0;
            bit_cnt      <= '0;
            data_q       <= IDLE_LEVEL;
            data_valid_q <= 1'b0;
        end else begin
            // A word lands in the hold register unless it went straight into
            // an empty shifter; otherwise the hold empties whenever it moves.
            if (take && (hold_full || !move)) begin
                hold_full <= 1'b1;
            end else if (move) begin
                hold_full <= 1'b0;
            end

            if (move) begin
                state        <= SHIFT;
                bit_cnt      <= '0;
                data_q       <= lead_bit(load_word);
                data_valid_q <= 1'b1;
            end else if (state == SHIFT && !last_bit) begin
                bit_cnt      <= bit_cnt + CNT_W'(1);
                data_q       <= lead_bit(shift_word);
                data_valid_q <= 1'b1;
            end else begin
                state        <= IDLE;
                bit_cnt      <= '0;
                data_q       <= IDLE_LEVEL;
                data_valid_q <= 1'b0;
            end
        end
    end

    // Word storage carries no reset: its contents only matter once the
    // control state says a word is present.
    always_ff @(posedge clk) begin
        if (take && (hold_full || !move)) begin
            hold_word <= bus.in_data;
        end
        if (move) begin
            shift_word <= advance(load_word);
        end else if (state == SHIFT) begin
            shift_word <= advance(shift_word);
        end
    end

`ifdef PAT_SER_BYTE_CNT_EN
    // A word counts as emitted on the edge that ends its last bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_cnt <= '0;
        end else if (last_bit) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pat_ser.sv
// Self-checking bench for pat_ser: an MSB-first and an LSB-first instance see
// the same stimulus. The reference model is a bit queue: every accepted word
// appends its bits in line order, and one bit leaves the queue per clock.
module tb_pat_ser;
    import pat_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pat_ser_if #(.WIDTH(W)) bm ();
    pat_ser_if #(.WIDTH(W)) bl ();

`ifdef PAT_SER_BYTE_CNT_EN
    logic [15:0] cnt_m;
    logic [15:0] cnt_l;
`endif

    pat_ser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk),
        .reset(reset),
`ifdef PAT_SER_BYTE_CNT_EN
        .byte_cnt(cnt_m),
`endif
        .bus(bm)
    );

    pat_ser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk),
        .reset(reset),
`ifdef PAT_SER_BYTE_CNT_EN
        .byte_cnt(cnt_l),
`endif
        .bus(bl)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: queued {last_of_word, bit} entries for each bit order.
    logic [1:0]  qm[$];
    logic [1:0]  ql[$];
    logic        em_data = IDLE_LEVEL;
    logic        em_dv   = 1'b0;
    logic        em_last = 1'b0;
    logic        el_data = IDLE_LEVEL;
    logic        el_dv   = 1'b0;
    logic [15:0] exp_cnt = '0;

    // Directed-scenario capture of the observed streams.
    logic [15:0] cap_m = '0;
    logic [15:0] cap_l = '0;
    int          cap_n = 0;
    logic        last_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic tk, input logic [W-1:0] d);
        logic [1:0] t;
        if (!rst_v) begin
            qm.delete();
            ql.delete();
            em_data = IDLE_LEVEL; em_dv = 1'b0; em_last = 1'b0;
            el_data = IDLE_LEVEL; el_dv = 1'b0;
            exp_cnt = '0;
        end else begin
            if (em_dv && em_last) exp_cnt = exp_cnt + 16'd1;
            if (tk) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back({(i == W - 1), d[W-1-i]});
                    ql.push_back({(i == W - 1), d[i]});
                end
            end
            if (qm.size() > 0) begin
                t = qm.pop_front();
                em_data = t[0]; em_last = t[1]; em_dv = 1'b1;
            end else begin
                em_data = IDLE_LEVEL; em_last = 1'b0; em_dv = 1'b0;
            end
            if (ql.size() > 0) begin
                t = ql.pop_front();
                el_data = t[0]; el_dv = 1'b1;
            end else begin
                el_data = IDLE_LEVEL; el_dv = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs just after a falling edge, check in_ready,
    // advance the model on the rising edge, check outputs at the next fall.
    task automatic cycle(input logic rst_v, input logic v, input logic [W-1:0] d);
        logic exp_rdy;
        reset = rst_v;
        bm.in_valid = v; bm.in_data = d;
        bl.in_valid = v; bl.in_data = d;
        #1;
        // Ready while at most one word's worth of bits is still queued behind the line.
        exp_rdy = rst_v && (qm.size() <= W);
        last_rdy = bm.in_ready;
        chk("in_ready_m", bm.in_ready, exp_rdy);
        chk("in_ready_l", bl.in_ready, exp_rdy);
        @(posedge clk);
        model_edge(rst_v, v && exp_rdy, d);
        @(negedge clk);
        chk("data_m", bm.data, em_data);
        chk("dv_m", bm.data_valid, em_dv);
        chk("busy_m", bm.busy, em_dv);
        chk("data_l", bl.data, el_data);
        chk("dv_l", bl.data_valid, el_dv);
        chk("busy_l", bl.busy, el_dv);
`ifdef PAT_SER_BYTE_CNT_EN
        chk("byte_cnt_m", cnt_m, exp_cnt);
        chk("byte_cnt_l", cnt_l, exp_cnt);
`endif
        if (bm.data_valid === 1'b1) begin
            cap_m = {cap_m[14:0], bm.data};
            cap_l = {cap_l[14:0], bl.data};
            cap_n++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, '0);
    endtask

    initial begin
        reset = 1'b0;
        bm.in_valid = 1'b0; bm.in_data = '0;
        bl.in_valid = 1'b0; bl.in_data = '0;
        @(negedge clk);

        // Reset state
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 8'h5A);
        chk("rst_data", bm.data, 1'b1);
        chk("rst_dv", bm.data_valid, 1'b0);
        chk("rst_busy", bm.busy, 1'b0);

        // Single word 0x37, accepted on the first edge with reset high
        cap_m = '0; cap_l = '0; cap_n = 0;
        cycle(1'b1, 1'b1, 8'h37);
        chk("first_bit_m", bm.data, 1'b0);
        idle(10);
        chk("w37_bits", cap_n, 8);
        chk("w37_msb", cap_m[7:0], 8'h37);
        chk("w37_lsb", cap_l[7:0], 8'hEC);

        // Two words back to back
        cap_m = '0; cap_l = '0; cap_n = 0;
        cycle(1'b1, 1'b1, 8'hA5);
        cycle(1'b1, 1'b1, 8'h3C);
        idle(20);
        chk("pair_bits", cap_n, 16);
        chk("pair_msb", cap_m, 16'hA53C);

        // Three words offered continuously: back-pressure until last bit of word 1
        cycle(1'b1, 1'b1, 8'h11);
        cycle(1'b1, 1'b1, 8'h22);
        chk("bp_second", last_rdy, 1'b1);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 1'b1, 8'h33);
            chk("bp_ready", last_rdy, (k == 6));
        end
        idle(30);

        // Reset mid-word with a word held
        cycle(1'b1, 1'b1, 8'hFF);
        cycle(1'b1, 1'b1, 8'h00);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        chk("mid_rst_data", bm.data, 1'b1);
        chk("mid_rst_dv", bm.data_valid, 1'b0);
        chk("mid_rst_busy", bm.busy, 1'b0);
        cap_n = 0;
        idle(20);
        chk("mid_rst_quiet", cap_n, 0);

`ifdef PAT_SER_BYTE_CNT_EN
        // Three words counted after reset
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 8'h01);
        cycle(1'b1, 1'b1, 8'h02);
        for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1, 8'h03);
        idle(20);
        chk("byte_cnt_3", cnt_m, 16'd3);
        chk("byte_cnt_idle", bm.data, 1'b1);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic v;
            r = ($urandom_range(0, 63) != 0);
            v = ($urandom_range(0, 3) != 0);
            cycle(r, v, W'($urandom));
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pat_ser.md
PAT_SER -- requirements
Module: pat_ser

Interface
REQ-001 Parameter WIDTH, default 8: bits per input word, legal range 2..16.
REQ-002 Parameter MSB_FIRST, default 1: 1 = serialize MSB first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 in_valid  input  1  upstream word available on in_data.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_ready  output  1  block can take a word this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-008 data  output  1  serial bit stream for the downstream pattern detector; registered.
REQ-009 data_valid  output  1  data carries a payload bit this cycle; registered.
REQ-010 busy  output  1  shifter holds or emits a word, or the hold register is full.

Function
REQ-011 Datapath: one hold register (1 word + full flag) and one shift register (WIDTH bits + bit counter).
REQ-012 FSM states: IDLE (shifter empty), SHIFT (emitting bits); encoding 1 bit.
REQ-013 in_ready = (not hold_full) or (move this cycle); combinational; 0 while reset is low.
REQ-014 Accepted word goes to hold register; same-cycle move to shifter is allowed when shifter is empty or emitting its last bit.
REQ-015 IDLE -> SHIFT when hold_full or when a word is accepted directly into an empty shifter; the first bit appears on data the cycle after acceptance (latency 1).
REQ-016 In SHIFT, exactly one bit per cycle; data_valid = 1 for WIDTH consecutive cycles per word.
REQ-017 On last bit: if a word is held or accepted that cycle, load it and continue with no gap bit; otherwise go to IDLE.
REQ-018 Bit order per MSB_FIRST; bit counter counts 0..WIDTH-1 and wraps to 0 on load.
REQ-019 When data_valid = 0, data SHALL be 1 (idle-high line level).
REQ-020 Back-pressure: with shifter busy and hold full, in_ready = 0 until the last bit of the current word.
REQ-021 in_data sampled only on transfer; changes while in_ready = 0 have no effect.

Reset
REQ-022 While reset is low at a clk edge: state IDLE, hold_full 0, counter 0, data 1, data_valid 0, busy 0.
REQ-023 Reset mid-word discards the partial word and the held word; no further bits of either emitted.
REQ-024 First transfer possible on the first edge with reset high.

Configuration
REQ-025 Macro PAT_SER_BYTE_CNT_EN: defined adds output byte_cnt (16 bits) counting words fully emitted, reset to 0, wraps 65535 -> 0; undefined, port and counter absent, all other behaviour identical.

Structure
REQ-026 Shared package pat_pkg holds the FSM state typedef, IDLE_LEVEL constant (1'b1) and default WIDTH constant.
REQ-027 Single module; no sub-module — the hold register is too small to justify one.

Verification
REQ-028 Reset released, one word 8'h37 MSB_FIRST=1 -> data 0,0,1,1,0,1,1,1 on cycles 1..8, data_valid high 8 cycles; a pat instance downstream flags once.
REQ-029 Words 8'hA5 then 8'h3C with in_valid held -> 16 contiguous valid bits 10100101 00111100, no gap cycle.
REQ-030 Three words offered continuously -> first two accepted on consecutive cycles, in_ready 0 until bit 7 of word 1, third accepted on that cycle.
REQ-031 reset low at bit 3 of 8'hFF with 8'h00 held -> next cycle data 1, data_valid 0, busy 0, no bits of 8'h00 emitted.
REQ-032 MSB_FIRST=0, word 8'h37 -> data 1,1,1,0,1,1,0,0.
REQ-033 PAT_SER_BYTE_CNT_EN defined, 3 words sent -> byte_cnt 3 one cycle after the last bit; idle data stays 1.
